// File: rtl/adder_share_ctrl.sv
// Round-robin controller sharing one external 16-bit adder between two requesters.
// Optional subtract support is enabled with `define ADDER_CTRL_SUB_EN.
//
// state      | meaning
// ST_IDLE    | waiting for a request, arbitrates and grants
// ST_SETTLE  | operands held on the adder while the carry chain settles
// ST_RESP    | result captured, done pulse to the owner
module adder_share_ctrl #(
  parameter int SETTLE_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic [15:0] r0_a,
  input  logic [15:0] r0_b,
  input  logic        r0_cin,
  output logic        r0_gnt,
  output logic        r0_done,
  input  logic        r1_req,
  input  logic [15:0] r1_a,
  input  logic [15:0] r1_b,
  input  logic        r1_cin,
  output logic        r1_gnt,
  output logic        r1_done,
`ifdef ADDER_CTRL_SUB_EN
  input  logic        r0_sub,
  input  logic        r1_sub,
`endif
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [15:0] add_s,
  input  logic        add_cout,
  output logic [15:0] res_s,
  output logic        res_cout,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic        r_last_r1;
  logic        r_owner;
  logic [15:0] r_op_a;
  logic [15:0] r_op_b;
  logic        r_op_cin;
  logic [15:0] r_res_s;
  logic        r_res_cout;

  logic        w_idle;
  logic        w_pick1;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_grant;
  logic [15:0] w_sel_a;
  logic [15:0] w_sel_b;
  logic        w_sel_cin;
  logic [15:0] w_load_b;
  logic        w_load_cin;

  assign w_idle  = (r_state == ST_IDLE);
  // r_last_r1 = 1 means r1 was served last, so r0 wins a tie
  assign w_pick1 = r1_req & (~r0_req | ~r_last_r1);
  // gnt is combinational; masked during reset so every output reads 0
  assign w_gnt1  = w_idle & ~rst & w_pick1;
  assign w_gnt0  = w_idle & ~rst & r0_req & ~w_pick1;
  assign w_grant = w_gnt0 | w_gnt1;

  assign w_sel_a   = w_pick1 ? r1_a   : r0_a;
  assign w_sel_b   = w_pick1 ? r1_b   : r0_b;
  assign w_sel_cin = w_pick1 ? r1_cin : r0_cin;

`ifdef ADDER_CTRL_SUB_EN
  logic w_sel_sub;
  assign w_sel_sub  = w_pick1 ? r1_sub : r0_sub;
  // a - b is a + ~b + 1; res_cout = 1 then means no borrow
  assign w_load_b   = w_sel_sub ? ~w_sel_b : w_sel_b;
  assign w_load_cin = w_sel_sub ? 1'b1 : w_sel_cin;
`else
  assign w_load_b   = w_sel_b;
  assign w_load_cin = w_sel_cin;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 8'd0;
      r_last_r1  <= 1'b1;
      r_owner    <= 1'b0;
      r_op_a     <= 16'd0;
      r_op_b     <= 16'd0;
      r_op_cin   <= 1'b0;
      r_res_s    <= 16'd0;
      r_res_cout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state   <= ST_SETTLE;
            r_cnt     <= CNT_LOAD;
            r_owner   <= w_gnt1;
            r_last_r1 <= w_gnt1;
            r_op_a    <= w_sel_a;
            r_op_b    <= w_load_b;
            r_op_cin  <= w_load_cin;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == 8'd0) begin
            r_res_s    <= add_s;
            r_res_cout <= add_cout;
            r_state    <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign r0_gnt   = w_gnt0;
  assign r1_gnt   = w_gnt1;
  assign r0_done  = (r_state == ST_RESP) & ~r_owner;
  assign r1_done  = (r_state == ST_RESP) &  r_owner;
  assign add_a    = r_op_a;
  assign add_b    = r_op_b;
  assign add_cin  = r_op_cin;
  assign res_s    = r_res_s;
  assign res_cout = r_res_cout;
  assign busy     = ~w_idle;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl with a delayed behavioural 16-bit adder.
// Compile with ADDER_CTRL_SUB_EN defined to also exercise subtraction.
module tb_adder_share_ctrl;

  localparam int SC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_cin, r1_req, r1_cin;
  logic [15:0] r0_a, r0_b, r1_a, r1_b;
  logic        r0_gnt, r0_done, r1_gnt, r1_done;
  logic        r0_sub, r1_sub;
  logic [15:0] add_a, add_b, add_s, res_s;
  logic        add_cin, add_cout, res_cout, busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // settles well inside the 10 ns period, but only after the inputs are held
  assign #7 {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  adder_share_ctrl #(.SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_a(r0_a), .r0_b(r0_b), .r0_cin(r0_cin),
    .r0_gnt(r0_gnt), .r0_done(r0_done),
    .r1_req(r1_req), .r1_a(r1_a), .r1_b(r1_b), .r1_cin(r1_cin),
    .r1_gnt(r1_gnt), .r1_done(r1_done),
`ifdef ADDER_CTRL_SUB_EN
    .r0_sub(r0_sub), .r1_sub(r1_sub),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .res_s(res_s), .res_cout(res_cout), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic single_op(input string tag, input bit who, input logic [15:0] a,
                           input logic [15:0] b, input logic cin, input bit sub,
                           input logic [15:0] es, input logic ec);
    logic [15:0] eb;
    eb = sub ? ~b : b;
    @(posedge clk); #1;
    if (!who) begin
      r0_req = 1'b1; r0_a = a; r0_b = b; r0_cin = cin; r0_sub = sub;
    end else begin
      r1_req = 1'b1; r1_a = a; r1_b = b; r1_cin = cin; r1_sub = sub;
    end
    @(negedge clk);
    chk({tag, "_gnt"},   who ? r1_gnt : r0_gnt, 1);
    chk({tag, "_ngnt"},  who ? r0_gnt : r1_gnt, 0);
    chk({tag, "_busy0"}, busy, 0);
    @(posedge clk); #1;
    if (!who) begin
      r0_req = 1'b0; r0_a = ~a; r0_b = ~b; r0_cin = ~cin; r0_sub = ~sub;
    end else begin
      r1_req = 1'b0; r1_a = ~a; r1_b = ~b; r1_cin = ~cin; r1_sub = ~sub;
    end
    for (int k = 1; k <= SC + 1; k++) begin
      @(negedge clk);
      chk({tag, "_busy"},  busy, 1);
      chk({tag, "_done"},  who ? r1_done : r0_done, (k == SC + 1) ? 1 : 0);
      chk({tag, "_ndone"}, who ? r0_done : r1_done, 0);
      chk({tag, "_adda"},  add_a, a);
      chk({tag, "_addb"},  add_b, eb);
    end
    chk({tag, "_res_s"},    res_s, es);
    chk({tag, "_res_cout"}, res_cout, ec);
    @(negedge clk);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_pulse"}, who ? r1_done : r0_done, 0);
    chk({tag, "_hold"}, res_s, es);
  endtask

  initial begin
    rst = 1'b1;
    r0_req = 0; r0_a = 0; r0_b = 0; r0_cin = 0; r0_sub = 0;
    r1_req = 0; r1_a = 0; r1_b = 0; r1_cin = 0; r1_sub = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_res", {res_cout, res_s}, 0);
    chk("rst_add", {add_cin, add_a, add_b}, 0);
    chk("rst_flags", {r0_gnt, r1_gnt, r0_done, r1_done}, 0);
    @(posedge clk); #1 rst = 1'b0;

    single_op("add1", 1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    single_op("carry", 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    single_op("cin1", 1'b0, 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0);

    // contention from reset release
    @(posedge clk); #1;
    rst = 1'b1;
    r0_req = 1; r0_a = 16'h0001; r0_b = 16'h0001; r0_cin = 0;
    r1_req = 1; r1_a = 16'h8000; r1_b = 16'h8000; r1_cin = 0;
    @(negedge clk);
    chk("cont_rst_gnt", {r0_gnt, r1_gnt}, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("cont_gnt0",  r0_gnt,  (c % 20 == 0)  ? 1 : 0);
      chk("cont_gnt1",  r1_gnt,  (c % 20 == 10) ? 1 : 0);
      chk("cont_done0", r0_done, (c % 20 == 9)  ? 1 : 0);
      chk("cont_done1", r1_done, (c % 20 == 19) ? 1 : 0);
      if (c % 20 == 9)  chk("cont_res0", {res_cout, res_s}, 17'h00002);
      if (c % 20 == 19) chk("cont_res1", {res_cout, res_s}, 17'h10000);
    end
    @(posedge clk); #1; r0_req = 0; r1_req = 0;
    @(negedge clk);
    chk("cont_idle", busy, 0);

    // r1 arrives while busy; r1 operands scrambled after its grant
    @(posedge clk); #1;
    r0_req = 1; r0_a = 16'h1111; r0_b = 16'h2222; r0_cin = 0;
    @(negedge clk);
    chk("blk_gnt0", r0_gnt, 1);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) r0_req = 0;
      if (k == 3) begin r1_req = 1; r1_a = 16'h0100; r1_b = 16'h0200; r1_cin = 1; end
      if (k == 11) begin r1_req = 0; r1_a = 16'hFFFF; r1_b = 16'hFFFF; r1_cin = 0; end
      @(negedge clk);
      chk("blk_gnt1",  r1_gnt,  (k == 10) ? 1 : 0);
      chk("blk_gnt0x", r0_gnt, 0);
      chk("blk_done0", r0_done, (k == 9) ? 1 : 0);
      chk("blk_done1", r1_done, (k == 19) ? 1 : 0);
      if (k == 9)  chk("blk_res0", {res_cout, res_s}, 17'h03333);
      if (k == 19) chk("blk_res1", {res_cout, res_s}, 17'h00301);
    end

    // reset in the middle of SETTLE with r0_req still held
    @(posedge clk); #1;
    r0_req = 1; r0_a = 16'h0A0A; r0_b = 16'h0505; r0_cin = 0;
    @(negedge clk);
    chk("mrst_gnt", r0_gnt, 1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 4) rst = 1'b1;
      @(negedge clk);
      chk("mrst_done", r0_done, 0);
    end
    chk("mrst_busy", busy, 0);
    chk("mrst_res", {res_cout, res_s}, 0);
    chk("mrst_add", {add_cin, add_a, add_b}, 0);
    chk("mrst_gntx", {r0_gnt, r1_gnt}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_regnt", r0_gnt, 1);
    @(posedge clk); #1 r0_req = 0;
    for (int k = 1; k <= SC + 1; k++) begin
      @(negedge clk);
      chk("mrst_done2", r0_done, (k == SC + 1) ? 1 : 0);
    end
    chk("mrst_res2", {res_cout, res_s}, 17'h00F0F);

`ifdef ADDER_CTRL_SUB_EN
    single_op("sub1", 1'b0, 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
    single_op("sub2", 1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
